// File: rtl/tdm_demultiplexer.sv
// TDM serial-link receiver: finds frame alignment from sync and steers MSB-first bits into NUM_CH channel words.
// Latency: word and its one-cycle strobe appear the cycle after its LSB. No backpressure: en=0 simply stalls all state.
module tdm_demultiplexer #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sin,
    input  logic                     sync,
    output logic [NUM_CH*CH_W-1:0]   ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     frame_done,
    output logic                     locked,
    output logic                     sync_err
);
    localparam int BW = $clog2(CH_W);
    localparam int CW = $clog2(NUM_CH);
    localparam logic [BW-1:0] BIT_LAST = BW'(CH_W - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

    typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]           ch_cnt_q, ch_cnt_d;
    logic [CH_W-2:0]         shreg_q, shreg_d;
    logic [NUM_CH*CH_W-1:0]  ch_data_q, ch_data_d;
    logic [NUM_CH-1:0]       ch_valid_q, ch_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    sync_err_q, sync_err_d;

    logic                    at_boundary;
    logic [CH_W-1:0]         word;

    assign at_boundary = (bit_cnt_q == '0) && (ch_cnt_q == '0);
    assign word        = {shreg_q, sin};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                HUNT:    if (sync) state_d = RECV;
                RECV:    if (at_boundary && !sync) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        locked     = (state_q == RECV);
        ch_data    = ch_data_q;
        ch_valid   = ch_valid_q;
        frame_done = frame_done_q;
        sync_err   = sync_err_q;
    end

    // Datapath: a sync seen anywhere but the frame boundary restarts channel 0 with this bit as its MSB.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        ch_cnt_d     = ch_cnt_q;
        shreg_d      = shreg_q;
        ch_data_d    = ch_data_q;
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        if (en) begin
            if (state_q == HUNT) begin
                if (sync) begin
                    shreg_d    = '0;
                    shreg_d[0] = sin;
                    bit_cnt_d  = BW'(1);
                    ch_cnt_d   = '0;
                end
            end else if (at_boundary && !sync) begin
                sync_err_d = 1'b1;
                shreg_d    = '0;
                bit_cnt_d  = '0;
                ch_cnt_d   = '0;
            end else if (!at_boundary && sync) begin
                sync_err_d = 1'b1;
                shreg_d    = '0;
                shreg_d[0] = sin;
                bit_cnt_d  = BW'(1);
                ch_cnt_d   = '0;
            end else begin
                shreg_d = word[CH_W-2:0];
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_cnt_q == CW'(k)) begin
                            ch_data_d[k*CH_W +: CH_W] = word;
                            ch_valid_d[k]             = 1'b1;
                        end
                    end
                    if (ch_cnt_q == CH_LAST) begin
                        ch_cnt_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        ch_cnt_d = ch_cnt_q + CW'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q    <= '0;
            ch_cnt_q     <= '0;
            shreg_q      <= '0;
            ch_data_q    <= '0;
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            ch_cnt_q     <= ch_cnt_d;
            shreg_q      <= shreg_d;
            ch_data_q    <= ch_data_d;
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end
endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer: linear frame-position model checked every cycle plus hand-computed scenario results.
module tb_tdm_demultiplexer;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    en = 1'b0;
    logic                    sin = 1'b0;
    logic                    sync = 1'b0;
    logic [NUM_CH*CH_W-1:0]  ch_data;
    logic [NUM_CH-1:0]       ch_valid;
    logic                    frame_done;
    logic                    locked;
    logic                    sync_err;

    tdm_demultiplexer #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sin(sin), .sync(sync),
        .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    int bitn = 0;
    bit chk_on = 1'b0;
    bit gap_mode = 1'b0;

    // Model state: aligned flag, linear bit position within the frame, partial word
    bit                      m_aligned = 1'b0;
    int                      m_pos = 0;
    int                      m_word = 0;
    int                      m_ch;
    logic [NUM_CH*CH_W-1:0]  m_data = '0;
    logic [NUM_CH-1:0]       m_vld = '0;
    logic                    m_fd = 1'b0;
    logic                    m_err = 1'b0;

    logic [NUM_CH-1:0] vlog[$];
    int                tlog[$];
    int                fd_cnt = 0;
    int                err_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    always @(posedge clk) begin
        m_vld = '0;
        m_fd  = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            m_aligned = 1'b0;
            m_pos     = 0;
            m_word    = 0;
            m_data    = '0;
        end else if (en) begin
            if (!m_aligned) begin
                if (sync) begin
                    m_aligned = 1'b1;
                    m_pos     = 1;
                    m_word    = int'(sin);
                end
            end else if (m_pos == 0 && !sync) begin
                m_err     = 1'b1;
                m_aligned = 1'b0;
            end else if (m_pos != 0 && sync) begin
                m_err  = 1'b1;
                m_pos  = 1;
                m_word = int'(sin);
            end else begin
                m_word = m_word * 2 + int'(sin);
                m_pos++;
                if (m_pos % CH_W == 0) begin
                    m_ch = m_pos / CH_W - 1;
                    m_data[m_ch*CH_W +: CH_W] = m_word[CH_W-1:0];
                    m_vld[m_ch] = 1'b1;
                    m_fd   = (m_ch == NUM_CH - 1);
                    m_word = 0;
                end
                if (m_pos == NUM_CH * CH_W) m_pos = 0;
            end
        end
    end

    always @(negedge clk) begin
        cyc_n++;
        if (chk_on) begin
            chk("ch_data", 64'(ch_data), 64'(m_data));
            chk("ch_valid", 64'(ch_valid), 64'(m_vld));
            chk("frame_done", 64'(frame_done), 64'(m_fd));
            chk("locked", 64'(locked), 64'(m_aligned));
            chk("sync_err", 64'(sync_err), 64'(m_err));
            if (ch_valid != '0) begin
                vlog.push_back(ch_valid);
                tlog.push_back(cyc_n);
            end
            if (frame_done) fd_cnt++;
            if (sync_err) err_cnt++;
        end
    end

    task automatic cyc(input logic e, input logic s, input logic y);
        en = e; sin = s; sync = y;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [CH_W-1:0] w, input logic first_sync);
        for (int i = 0; i < CH_W; i++) begin
            cyc(1'b1, w[CH_W-1-i], first_sync && (i == 0));
            if (first_sync && i == 0) chk("locked_after_sync", 64'(locked), 64'd1);
            bitn++;
            if (gap_mode && (bitn % 5 == 0)) begin
                for (int g = 0; g < 3; g++) begin
                    cyc(1'b0, 1'b1, 1'b1);
                    chk("gap_quiet", 64'({ch_valid, frame_done, sync_err}), 64'd0);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [NUM_CH*CH_W-1:0] f);
        for (int k = 0; k < NUM_CH; k++) send_word(f[k*CH_W +: CH_W], k == 0);
    endtask

    task automatic clear_log();
        vlog.delete();
        tlog.delete();
        fd_cnt  = 0;
        err_cnt = 0;
    endtask

    function automatic int log_code();
        int c = 0;
        foreach (vlog[i]) c = (c << 4) | int'(vlog[i]);
        return c;
    endfunction

    function automatic int log_span();
        if (tlog.size() == 0) return -1;
        return tlog[tlog.size()-1] - tlog[0];
    endfunction

    initial begin
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk_on = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        chk("reset_data", 64'(ch_data), 64'd0);
        chk("reset_flags", 64'({ch_valid, frame_done, locked, sync_err}), 64'd0);
        rst_n = 1'b1;

        // Single aligned frame
        clear_log();
        send_frame(32'h01FF3CA5);
        cyc(1'b0, 1'b0, 1'b0);
        chk("f1_data", 64'(ch_data), 64'h01FF3CA5);
        chk("f1_strobes", 64'(log_code()), 64'h1248);
        chk("f1_span", 64'(log_span()), 64'd24);
        chk("f1_frame_done", 64'(fd_cnt), 64'd1);

        // Same frame with 3-cycle en gaps after every 5th bit
        clear_log();
        gap_mode = 1'b1;
        bitn = 0;
        send_frame(32'h01FF3CA5);
        gap_mode = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        chk("gap_data", 64'(ch_data), 64'h01FF3CA5);
        chk("gap_strobes", 64'(log_code()), 64'h1248);
        chk("gap_span", 64'(log_span()), 64'd39);
        chk("gap_err", 64'(err_cnt), 64'd0);

        // Back-to-back frames
        clear_log();
        send_frame(32'h01FF3CA5);
        send_frame(32'h44332211);
        cyc(1'b0, 1'b0, 1'b0);
        chk("b2b_data", 64'(ch_data), 64'h44332211);
        chk("b2b_err", 64'(err_cnt), 64'd0);
        chk("b2b_frame_done", 64'(fd_cnt), 64'd2);

        // Sync arrives on bit 3 of channel 2
        clear_log();
        send_word(8'h10, 1'b1);
        send_word(8'h20, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        send_frame(32'hEFBEADDE);
        cyc(1'b0, 1'b0, 1'b0);
        chk("resync_err", 64'(err_cnt), 64'd1);
        chk("resync_strobes", 64'(log_code()), 64'h121248);
        chk("resync_data", 64'(ch_data), 64'hEFBEADDE);

        // Missing sync at the frame boundary drops lock
        clear_log();
        send_word(8'h77, 1'b0);
        send_word(8'h0F, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("lost_err", 64'(err_cnt), 64'd1);
        chk("lost_locked", 64'(locked), 64'd0);
        chk("lost_data", 64'(ch_data), 64'hEFBEADDE);
        chk("lost_strobes", 64'(log_code()), 64'd0);

        // Reset midway through channel 1
        send_word(8'h12, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        chk("midrst_data", 64'(ch_data), 64'd0);
        chk("midrst_flags", 64'({ch_valid, frame_done, locked, sync_err}), 64'd0);
        clear_log();
        send_frame(32'hBEBAFECA);
        cyc(1'b0, 1'b0, 1'b0);
        chk("postrst_data", 64'(ch_data), 64'hBEBAFECA);
        chk("postrst_strobes", 64'(log_code()), 64'h1248);
        chk("postrst_err", 64'(err_cnt), 64'd0);

        cyc(1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
- Receiving end of the team's time-division-multiplexed serial link. The transmitter interleaves NUM_CH channel words onto one bit lane, MSB first, and marks each frame start with a sync flag.
- This block recovers frame alignment and steers each bit back to its channel.
- It presents each completed word on that channel's parallel output with a one-cycle valid strobe.
- Sits between the serial link input and the per-channel consumers.

Parameters:
- NUM_CH, 4, number of interleaved channels per frame (>= 2).
- CH_W, 8, bits per channel word (>= 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- en  input  1  bit-valid qualifier; sin and sync are sampled only when en=1.
- sin  input  1  serial data bit.
- sync  input  1  frame marker; high together with bit 0 (MSB) of channel 0.
- ch_data  output  NUM_CH*CH_W  channel words; channel k occupies bits [k*CH_W +: CH_W]. Each slice holds its value until overwritten.
- ch_valid  output  NUM_CH  one-cycle pulse; bit k is high when channel k's slice was just updated.
- frame_done  output  1  one-cycle pulse when the last channel of a frame completes.
- locked  output  1  high while aligned (RECV state).
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (rst_n=0 at a clock edge), all outputs and state registers cleared:
  - ch_data=0, ch_valid=0, frame_done=0, locked=0, sync_err=0.
  - State=HUNT, bit_cnt=0, ch_cnt=0, shift register=0.
  - Reset mid-frame discards the partial word; no strobes are emitted.
- Cycles with en=0: no state change; all pulse outputs low; sin/sync ignored.
- State HUNT (locked=0):
  - en=1, sync=0: bit discarded.
  - en=1, sync=1: bit taken as MSB of channel 0; bit_cnt=1, ch_cnt=0; go to RECV.
- State RECV (locked=1), each en=1 cycle:
  - Shift sin into the word shift register, MSB first.
  - bit_cnt increments 0..CH_W-1 and wraps.
  - On the edge capturing bit CH_W-1:
    - The completed word (shift register with sin as LSB) is written to slice ch_cnt.
    - ch_valid[ch_cnt]=1 for exactly the next cycle.
    - ch_cnt increments.
  - When ch_cnt=NUM_CH-1 completes, frame_done=1 in the same cycle as its ch_valid, and ch_cnt wraps to 0.
- Latency: a word is visible on ch_data and strobed in the cycle after its LSB is sampled. No extra latency from en gaps beyond the gap itself.
- Sync checking in RECV (applies only to en=1 bits):
  - Frame-boundary bit (bit_cnt=0, ch_cnt=0) with sync=1: normal; no error.
  - Frame-boundary bit with sync=0: sync_err pulse; bit discarded; go to HUNT; locked drops next cycle.
  - sync=1 at any other position: sync_err pulse; partial word discarded, with no ch_valid for it. That bit becomes MSB of channel 0 (bit_cnt=1, ch_cnt=0); stay in RECV.
  - The first sync accepted in HUNT never raises sync_err.
- Simultaneous events:
  - Only one ch_valid bit is high in any cycle.
  - frame_done coincides only with ch_valid[NUM_CH-1].
  - sync_err never coincides with ch_valid.
- Sizing:
  - bit_cnt width is clog2(CH_W); ch_cnt width is clog2(NUM_CH).
  - Counters compare against CH_W-1 and NUM_CH-1 explicitly, so non-power-of-two sizes wrap correctly.
- Slices of ch_data not being written retain their values, including across HUNT periods.

Test Plan (NUM_CH=4, CH_W=8):
- Reset, then a continuous frame of 0xA5,0x3C,0xFF,0x01 with sync on the first bit:
  - locked=1 from the cycle after the first bit.
  - ch_valid pulses 0001, 0010, 0100, 1000 at 8-bit spacing; frame_done with 1000.
  - ch_data=0x01FF3CA5.
- Same frame with en low for 3 cycles after every 5th bit: identical ch_data, strobes delayed only by the gaps, and no pulses during en=0.
- Two back-to-back frames, with the second carrying 0x11,0x22,0x33,0x44 and sync on its first bit: no sync_err; ch_data=0x44332211.
- Sync asserted on bit 3 of channel 2, then a full frame 0xDE,0xAD,0xBE,0xEF:
  - One sync_err pulse; no ch_valid for the partial channel 2.
  - The next strobes are 0001 and so on; ch_data=0xEFBEADDE.
- After a good frame, the next frame-boundary bit arrives with sync=0:
  - sync_err pulse; locked=0.
  - The following bits are ignored until a sync; ch_data is unchanged.
- rst_n=0 for one cycle midway through channel 1:
  - All outputs 0 and locked=0.
  - A subsequent full frame decodes correctly.
